uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among NUM_REQ byte-stream requesters (command responder, status reporter, debug dump, etc.). Round-robin arbitration with packet lock, CTS flow control, and a burst limit against starvation. Sits between the requesters and the UART serializer in the monitor top level; the serializer runs off the baud generator and reports back via tx_busy.

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the
// default byte width.
package uart_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } tx_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above
// i_ptr, wrapping around, returned both one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    logic [PTR_W-1:0] w_cand;

    // Scan requesters in priority order starting at i_ptr; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer among NUM_REQ byte-stream requesters.
// Round-robin with packet lock: the owner keeps the grant until it sends a
// byte marked last or until MAX_BURST bytes have gone out, then the pointer
// moves past it. Bytes are only accepted while the peer's CTS is asserted.
//
// Handshake: a requester's byte transfers on a clock edge where both its
// req_valid and req_ready are high. req_ready is only ever high for the
// current owner, in GRANT, with CTS ok and the serializer idle. tx_start is a
// one-cycle pulse; tx_data holds the byte until the next transfer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk50,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      uart_cts,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output tx_arb_state_t             dbg_state,
    output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0]  BURST_LIM = BC_W'(MAX_BURST);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    tx_arb_state_t      r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [BC_W-1:0]    r_burst;
    logic               r_last;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_cts_meta;
    logic               r_cts_sync;

    logic               w_cts_ok;
    logic               w_any;
    logic               w_hs;
    logic               w_rotate;
    logic [NUM_REQ-1:0] w_pick_grant;
    logic [PTR_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [DATA_W-1:0]  w_owner_data;
    logic               w_owner_last;

    // Two-flop synchronizer for the asynchronous, active-low CTS input.
    // Resets to 1 so nothing is sent until CTS is seen asserted.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= uart_cts;
            r_cts_sync <= r_cts_meta;
        end
    end

    assign w_cts_ok = ~r_cts_sync;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    // Select the owner's byte and last flag; other requesters are ignored.
    always_comb begin
        w_owner_data = '0;
        w_owner_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == PTR_W'(k)) begin
                w_owner_data = req_data[k*DATA_W +: DATA_W];
                w_owner_last = req_last[k];
            end
        end
    end

    // Ready only towards the owner, only in GRANT, only with CTS and an idle serializer.
    always_comb begin
        w_ready = '0;
        if (r_state == ST_GRANT && w_cts_ok && !tx_busy) begin
            w_ready = r_grant;
        end
    end

    assign w_hs     = |(w_ready & req_valid);
    assign w_rotate = r_last || (r_burst == BURST_LIM);

    // Arbitration / transmit FSM.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_burst   <= '0;
            r_last    <= 1'b0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick_idx;
                        r_grant <= w_pick_grant;
                        r_burst <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Owner going quiet keeps the grant: packets are never split.
                    if (w_hs) begin
                        r_tx_data <= w_owner_data;
                        r_last    <= w_owner_last;
                        r_burst   <= r_burst + 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (w_rotate) begin
                            r_grant  <= '0;
                            r_rr_ptr <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state <= ST_GRANT;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign grant      = r_grant;
    assign tx_start   = (r_state == ST_START);
    assign tx_data    = r_tx_data;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester source queues, a serializer model,
// and a scoreboard of expected {grant, byte} pairs checked at each tx_start.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int BUSY_CYC  = 4;
    localparam int PTR_W     = $clog2(NUM_REQ);
    localparam int SB_W      = NUM_REQ + DATA_W;

    logic                      clk50 = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      uart_cts;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    tx_arb_state_t             dbg_state;
    logic [PTR_W-1:0]          dbg_rr_ptr;

    logic [DATA_W:0]   src_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] hold;
    logic [SB_W-1:0]   exp_q [$];
    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk50      (clk50),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .uart_cts   (uart_cts),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // Clock and watchdog
    always #10 clk50 = ~clk50;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_src(input int req, input logic [DATA_W-1:0] data, input logic last);
        src_q[req].push_back({last, data});
    endtask

    task automatic push_exp(input int req, input logic [DATA_W-1:0] data);
        logic [NUM_REQ-1:0] g;
        g = NUM_REQ'(1) << req;
        exp_q.push_back({g, data});
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (n < 3000 && !(exp_q.size() == 0 && src_empty() && dbg_state == ST_IDLE && !tx_busy)) begin
            @(negedge clk50);
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
    endtask

    // Requester driver: retire handshaken bytes, present the next queued byte.
    initial begin
        logic [NUM_REQ-1:0] hs;
        logic [DATA_W:0]    head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk50);
            hs = req_valid & req_ready;
            @(posedge clk50);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && !hold[i]) begin
                    head = src_q[i][0];
                    req_valid[i] = 1'b1;
                    req_data[i*DATA_W +: DATA_W] = head[DATA_W-1:0];
                    req_last[i] = head[DATA_W];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*DATA_W +: DATA_W] = '0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // Serializer model: busy for BUSY_CYC cycles starting the cycle after tx_start.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk50);
            if (tx_start) begin
                @(posedge clk50);
                #1 tx_busy = 1'b1;
                repeat (BUSY_CYC) @(posedge clk50);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every tx_start must match the head of exp_q.
    initial begin
        logic [SB_W-1:0] e;
        forever begin
            @(negedge clk50);
            if (reset && tx_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got grant 0x%0h data 0x%0h with nothing expected at %0t", grant, tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'({grant, tx_data}), 32'(e));
                end
            end
        end
    end

    // Directed sequence
    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        hold     = '0;
        uart_cts = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clk50);

        chk("rst_grant",    32'(grant),      32'd0);
        chk("rst_ready",    32'(req_ready),  32'd0);
        chk("rst_tx_start", 32'(tx_start),   32'd0);
        chk("rst_tx_data",  32'(tx_data),    32'd0);
        chk("rst_state",    32'(dbg_state),  32'(ST_IDLE));
        chk("rst_rr_ptr",   32'(dbg_rr_ptr), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk50);

        // Single byte from requester 2, exact cycle timing
        push_src(2, 8'h5A, 1'b1);
        push_exp(2, 8'h5A);
        n = 0;
        while (!req_valid[2] && n < 10) begin
            @(negedge clk50);
            n++;
        end
        chk("single_valid_seen", 32'(n < 10), 32'd1);
        chk("single_grant_n",    32'(grant), 32'd0);
        @(negedge clk50);
        chk("single_grant_n1",   32'(grant),     32'b0100);
        chk("single_ready_n1",   32'(req_ready), 32'b0100);
        @(negedge clk50);
        chk("single_start_n2",   32'(tx_start), 32'd1);
        chk("single_data_n2",    32'(tx_data),  32'h5A);
        drain("single_drain");
        chk("single_grant_end",  32'(grant),      32'd0);
        chk("single_rr_ptr",     32'(dbg_rr_ptr), 32'd3);

        // Contention from reset: 0, 1 and 3 each send a 2-byte packet
        reset = 1'b0;
        @(negedge clk50);
        reset = 1'b1;
        @(negedge clk50);
        push_src(0, 8'h10, 1'b0); push_src(0, 8'h11, 1'b1);
        push_src(1, 8'h20, 1'b0); push_src(1, 8'h21, 1'b1);
        push_src(3, 8'h40, 1'b0); push_src(3, 8'h41, 1'b1);
        push_exp(0, 8'h10); push_exp(0, 8'h11);
        push_exp(1, 8'h20); push_exp(1, 8'h21);
        push_exp(3, 8'h40); push_exp(3, 8'h41);
        drain("contention_drain");
        chk("contention_rr_ptr", 32'(dbg_rr_ptr), 32'd0);

        // CTS deasserted blocks everything; reassertion opens ready quickly
        uart_cts = 1'b1;
        repeat (3) @(negedge clk50);
        push_src(1, 8'h3C, 1'b1);
        push_exp(1, 8'h3C);
        cnt_a = 0;
        repeat (20) begin
            @(negedge clk50);
            if (req_ready != '0 || tx_start) cnt_a++;
        end
        chk("cts_blocked", 32'(cnt_a), 32'd0);
        chk("cts_grant",   32'(grant), 32'b0010);
        @(posedge clk50);
        #1 uart_cts = 1'b0;
        n = 0;
        while (req_ready == '0 && n < 10) begin
            @(negedge clk50);
            n++;
        end
        chk("cts_ready_latency", 32'(n <= 3), 32'd1);
        drain("cts_drain");

        // Burst limit of 4: requester 0 streams 10 bytes, requester 1 two singles
        for (int k = 0; k < 10; k++) push_src(0, 8'(8'hB0 + k), 1'(k == 9));
        push_src(1, 8'hC0, 1'b1);
        push_src(1, 8'hC1, 1'b1);
        for (int k = 0; k < 4; k++) push_exp(0, 8'(8'hB0 + k));
        push_exp(1, 8'hC0);
        for (int k = 4; k < 8; k++) push_exp(0, 8'(8'hB0 + k));
        push_exp(1, 8'hC1);
        push_exp(0, 8'hB8);
        push_exp(0, 8'hB9);
        drain("burst_drain");
        chk("burst_rr_ptr", 32'(dbg_rr_ptr), 32'd1);

        // Packet lock: owner 0 pauses after byte 1 of 3 while requester 1 waits
        push_src(0, 8'hD0, 1'b0);
        push_src(0, 8'hD1, 1'b0);
        push_src(0, 8'hD2, 1'b1);
        push_exp(0, 8'hD0); push_exp(0, 8'hD1); push_exp(0, 8'hD2);
        push_exp(1, 8'hE0);
        n = 0;
        while (src_q[0].size() != 2 && n < 100) begin
            @(negedge clk50);
            n++;
        end
        chk("lock_first_byte", 32'(n < 100), 32'd1);
        hold[0] = 1'b1;
        push_src(1, 8'hE0, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        repeat (50) begin
            @(negedge clk50);
            if (req_ready[1]) cnt_a++;
            if (grant != 4'b0001) cnt_b++;
        end
        chk("lock_other_ready", 32'(cnt_a), 32'd0);
        chk("lock_grant_moved", 32'(cnt_b), 32'd0);
        hold[0] = 1'b0;
        drain("lock_drain");
        chk("lock_rr_ptr", 32'(dbg_rr_ptr), 32'd2);

        // Reset during WAIT_DONE, then arbitration restarts from pointer 0
        push_src(3, 8'hF0, 1'b0);
        push_src(3, 8'hF1, 1'b1);
        push_exp(3, 8'hF0);
        n = 0;
        while (dbg_state != ST_WAIT_DONE && n < 100) begin
            @(negedge clk50);
            n++;
        end
        chk("rstmid_reach_wait_done", 32'(n < 100), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_grant",    32'(grant),      32'd0);
        chk("rstmid_tx_start", 32'(tx_start),   32'd0);
        chk("rstmid_ready",    32'(req_ready),  32'd0);
        chk("rstmid_tx_data",  32'(tx_data),    32'd0);
        chk("rstmid_state",    32'(dbg_state),  32'(ST_IDLE));
        chk("rstmid_rr_ptr",   32'(dbg_rr_ptr), 32'd0);
        chk("rstmid_expq",     32'(exp_q.size()), 32'd0);
        src_q[3].delete();
        @(negedge clk50);
        reset = 1'b1;
        @(negedge clk50);
        push_src(3, 8'h63, 1'b1);
        push_src(1, 8'h61, 1'b1);
        push_exp(1, 8'h61);
        push_exp(3, 8'h63);
        drain("rstmid_drain");

        chk("final_expq_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
